// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    localparam int unsigned DEF_WIDTH  = 8;
    localparam int unsigned DEF_DIGITS = 3;

    // Double-dabble digit correction: any digit >= 5 gets +3 before the shift
    localparam logic [3:0] ADJ_THRESHOLD = 4'd5;
    localparam logic [3:0] ADJ_ADD       = 4'd3;

endpackage

// File: rtl/bin2bcd_seq_adj.sv
// Combinational per-digit correction step of the shift-add-3 algorithm.
module bcd_digit_adj
    import bin2bcd_pkg::*;
(
    input  logic [3:0] digit,
    output logic [3:0] adjusted
);

    // Add 3 to digits at or above the threshold; 4-bit wrap is intentional
    always_comb begin
        adjusted = digit;
        if (digit >= ADJ_THRESHOLD) begin
            adjusted = digit + ADJ_ADD;
        end
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter, one input bit per clock (double dabble).
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int unsigned WIDTH  = DEF_WIDTH,
    parameter int unsigned DIGITS = DEF_DIGITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int unsigned SW    = 4 * DIGITS;
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [SW-1:0]    scratch;
    logic [SW-1:0]    scratch_adj;
    logic [SW-1:0]    scratch_next;
    logic [CNT_W-1:0] cnt;

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_adj
            bcd_digit_adj u_adj (
                .digit    (scratch[4*g +: 4]),
                .adjusted (scratch_adj[4*g +: 4])
            );
        end
    endgenerate

    // Adjusted scratch shifted left by one, pulling in the next binary MSB
    always_comb begin
        scratch_next = SW'({scratch_adj, shreg[WIDTH-1]});
    end

    // Control FSM with datapath registers and registered handshake outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            shreg   <= '0;
            scratch <= '0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            bcd     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        shreg   <= bin;
                        scratch <= '0;
                        cnt     <= CNT_W'(WIDTH);
                        busy    <= 1'b1;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    shreg   <= shreg << 1;
                    scratch <= scratch_next;
                    cnt     <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        bcd   <= scratch_next;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq against a decimal-arithmetic reference.
module tb_bin2bcd_seq;

    localparam int unsigned WIDTH  = 8;
    localparam int unsigned DIGITS = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] bin;
    logic             busy;
    logic             done;
    logic [11:0]      bcd;

    int          errors = 0;
    int          checks = 0;
    logic [11:0] sb[$];
    logic [11:0] last_bcd = '0;
    logic [11:0] exp_mon;
    bit          stab_en = 1'b0;

    bin2bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd)
    );

    always #5 clk = ~clk;

    // Reference: decimal digits by plain division
    function automatic logic [11:0] ref_bcd(input int unsigned v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every done pulse, checks bcd holds otherwise
    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                exp_mon = sb.pop_front();
                check("bcd_result", bcd, exp_mon);
            end
            check("digit_range",
                  (bcd[3:0] <= 4'd9 && bcd[7:4] <= 4'd9 && bcd[11:8] <= 4'd9) ? 1 : 0, 1);
            last_bcd = bcd;
        end else if (stab_en) begin
            check("bcd_hold", bcd, last_bcd);
        end
    end

    assert property (@(negedge clk) disable iff (rst)
        (bcd[3:0] <= 4'd9 && bcd[7:4] <= 4'd9 && bcd[11:8] <= 4'd9))
        else $error("FAIL digit_assert bcd=%h", bcd);

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Issue one conversion; optionally verify busy length and done latency
    task automatic convert(input logic [WIDTH-1:0] v, input bit timing);
        int unsigned waited;
        int unsigned busy_cnt;
        @(negedge clk);
        bin   = v;
        start = 1'b1;
        sb.push_back(ref_bcd(v));
        @(negedge clk);
        start    = 1'b0;
        bin      = WIDTH'($urandom);
        waited   = 0;
        busy_cnt = 0;
        while (!done && waited < 4 * WIDTH) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            waited++;
        end
        if (!done) check("done_timeout", 0, 1);
        if (timing) begin
            check("busy_cycles", busy_cnt, WIDTH);
            check("done_latency", waited + 1, WIDTH + 1);
        end
    endtask

    // Start held high and bin forced to FF throughout SHIFT
    task automatic start_spam();
        int unsigned waited;
        @(negedge clk);
        bin   = 8'd100;
        start = 1'b1;
        sb.push_back(ref_bcd(100));
        waited = 0;
        @(negedge clk);
        while (!done && waited < 4 * WIDTH) begin
            start = 1'b1;
            bin   = 8'hFF;
            @(negedge clk);
            waited++;
        end
        start = 1'b0;
        if (!done) check("spam_done_timeout", 0, 1);
        repeat (2 * WIDTH) begin
            @(negedge clk);
            check("spam_no_second_done", done, 0);
            check("spam_not_busy", busy, 0);
        end
    endtask

    // Reset four cycles into a conversion of 200, then redo it cleanly
    task automatic abort_test();
        @(negedge clk);
        bin   = 8'd200;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_busy_before", busy, 1);
        stab_en = 1'b0;
        rst     = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_bcd", bcd, 0);
        last_bcd = '0;
        stab_en  = 1'b1;
        repeat (2 * WIDTH) begin
            @(negedge clk);
            check("abort_no_done", done, 0);
        end
        convert(8'd200, 1'b1);
    endtask

    // rst and start on the same edge: start must be dropped
    task automatic rst_start_test();
        @(negedge clk);
        stab_en = 1'b0;
        rst     = 1'b1;
        start   = 1'b1;
        bin     = 8'd77;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        check("rststart_busy", busy, 0);
        check("rststart_bcd", bcd, 0);
        last_bcd = '0;
        stab_en  = 1'b1;
        repeat (WIDTH + 3) begin
            @(negedge clk);
            check("rststart_no_done", done, 0);
            check("rststart_no_busy", busy, 0);
        end
    endtask

    int unsigned bvals[4] = '{225, 255, 9, 10};
    int unsigned a_op;
    int unsigned b_op;

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        bin   = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_bcd", bcd, 0);
        rst     = 1'b0;
        stab_en = 1'b1;

        convert(8'd0, 1'b1);

        a_op = 7; b_op = 5;
        convert(WIDTH'(a_op * b_op), 1'b1);
        a_op = 8; b_op = 9;
        convert(WIDTH'(a_op * b_op), 1'b1);

        foreach (bvals[i]) convert(WIDTH'(bvals[i]), 1'b1);

        start_spam();
        convert(8'd123, 1'b1);

        abort_test();
        rst_start_test();

        for (int unsigned v = 0; v < 256; v++) convert(WIDTH'(v), 1'b1);

        repeat (40) convert(WIDTH'($urandom), 1'b0);

        repeat (5) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
